// File: rtl/pmi_fifo_sync_pkg.sv
// Shared definitions for the pmi_fifo_sync FIFO: show-ahead mode constants,
// the per-cycle transfer record and a constant-evaluable clog2 helper.
package pmi_fifo_sync_pkg;

    localparam int SHOWAHEAD_STD  = 0;
    localparam int SHOWAHEAD_FWFT = 1;

    typedef struct packed {
        logic wr;
        logic rd;
    } xfer_t;

    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width++;
            rem = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/pmi_fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read
// so the array maps onto distributed/LUT RAM. Contents are never reset.
module pmi_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pmi_fifo_sync.sv
// Single-clock FIFO with fill count, registered almost-flags, optional show-ahead
// output, synchronous flush and sticky overflow/underflow flags.
module pmi_fifo_sync
    import pmi_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int SHOWAHEAD  = SHOWAHEAD_STD,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Flush,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic                  ClrErr,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [AW:0]           Count,
    output logic                  Empty,
    output logic                  Full,
    output logic                  AlmostEmpty,
    output logic                  AlmostFull,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   CNT_AE   = (AW+1)'(AE_LEVEL);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count_nxt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  ovf_set;
    logic                  udf_set;
    xfer_t                 xfer;

    // Flush outranks both requests and also suppresses the error flags.
    always_comb begin
        xfer.wr = WrEn & ~Full  & ~Flush;
        xfer.rd = RdEn & ~Empty & ~Flush;
        ovf_set = WrEn &  Full  & ~Flush;
        udf_set = RdEn &  Empty & ~Flush;
    end

    always_comb begin
        count_nxt = Count;
        if (Flush) begin
            count_nxt = '0;
        end else if (xfer.wr && !xfer.rd) begin
            count_nxt = Count + CNT_ONE;
        end else if (xfer.rd && !xfer.wr) begin
            count_nxt = Count - CNT_ONE;
        end
    end

    pmi_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (Clock),
        .wr_en   (xfer.wr),
        .wr_addr (wr_ptr),
        .wr_data (Data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (xfer.wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (xfer.rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Flags come from the next count so they line up with Count itself.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Count       <= '0;
            Empty       <= 1'b1;
            Full        <= 1'b0;
            AlmostEmpty <= 1'b1;
            AlmostFull  <= 1'b0;
        end else begin
            Count       <= count_nxt;
            Empty       <= (count_nxt == '0);
            Full        <= (count_nxt == CNT_FULL);
            AlmostEmpty <= (count_nxt <= CNT_AE);
            AlmostFull  <= (count_nxt >= CNT_AF);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Overflow  <= ovf_set | (Overflow  & ~ClrErr);
            Underflow <= udf_set | (Underflow & ~ClrErr);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            q_reg <= '0;
        end else if (xfer.rd) begin
            q_reg <= rd_data;
        end
    end

    // In show-ahead mode an empty FIFO keeps presenting the last word popped.
    assign Q = (SHOWAHEAD == SHOWAHEAD_FWFT && !Empty) ? rd_data : q_reg;

endmodule

// File: tb/tb_pmi_fifo_sync.sv
// Self-checking bench for pmi_fifo_sync: standard and show-ahead instances share
// stimulus and are compared every cycle against a queue-based model.
module tb_pmi_fifo_sync;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] data;

    logic [7:0] q_s, q_f;
    logic [4:0] cnt_s, cnt_f;
    logic       emp_s, full_s, ae_s, af_s, ovf_s, udf_s;
    logic       emp_f, full_f, ae_f, af_f, ovf_f, udf_f;

    pmi_fifo_sync #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .SHOWAHEAD(0)) u_std (
        .Clock(clk), .Reset_n(rst_n), .Flush(flush), .Data(data), .WrEn(wr_en), .RdEn(rd_en),
        .ClrErr(clr_err), .Q(q_s), .Count(cnt_s), .Empty(emp_s), .Full(full_s),
        .AlmostEmpty(ae_s), .AlmostFull(af_s), .Overflow(ovf_s), .Underflow(udf_s)
    );

    pmi_fifo_sync #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .SHOWAHEAD(1)) u_fwft (
        .Clock(clk), .Reset_n(rst_n), .Flush(flush), .Data(data), .WrEn(wr_en), .RdEn(rd_en),
        .ClrErr(clr_err), .Q(q_f), .Count(cnt_f), .Empty(emp_f), .Full(full_f),
        .AlmostEmpty(ae_f), .AlmostFull(af_f), .Overflow(ovf_f), .Underflow(udf_f)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, Q as the last word popped.
    logic [7:0] mq[$];
    logic [7:0] m_q = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    bit         m_was_full;
    bit         m_was_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_q   = 8'h00;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            mq.delete();
        end else begin
            m_was_full  = (mq.size() == DEPTH);
            m_was_empty = (mq.size() == 0);
            if (rd_en && !m_was_empty) m_q = mq.pop_front();
            if (wr_en && !m_was_full) mq.push_back(data);
            m_ovf = (wr_en && m_was_full)  || (m_ovf && !clr_err);
            m_udf = (rd_en && m_was_empty) || (m_udf && !clr_err);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("count_std",  32'(cnt_s),  32'(mq.size()));
            check("empty_std",  32'(emp_s),  32'(mq.size() == 0));
            check("full_std",   32'(full_s), 32'(mq.size() == DEPTH));
            check("aempty_std", 32'(ae_s),   32'(mq.size() <= 2));
            check("afull_std",  32'(af_s),   32'(mq.size() >= 14));
            check("ovf_std",    32'(ovf_s),  32'(m_ovf));
            check("udf_std",    32'(udf_s),  32'(m_udf));
            check("q_std",      32'(q_s),    32'(m_q));
            check("count_fwft", 32'(cnt_f),  32'(mq.size()));
            check("empty_fwft", 32'(emp_f),  32'(mq.size() == 0));
            check("full_fwft",  32'(full_f), 32'(mq.size() == DEPTH));
            check("aempty_fwft",32'(ae_f),   32'(mq.size() <= 2));
            check("afull_fwft", 32'(af_f),   32'(mq.size() >= 14));
            check("ovf_fwft",   32'(ovf_f),  32'(m_ovf));
            check("udf_fwft",   32'(udf_f),  32'(m_udf));
            if (mq.size() > 0) check("q_fwft", 32'(q_f), 32'(mq[0]));
        end
    end

    // Called on a falling edge; returns on the next falling edge, after the DUT has clocked.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic f, input logic c);
        wr_en = w; rd_en = r; data = d; flush = f; clr_err = c;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(cnt_s), 32'd0);
        check("rst_empty", 32'(emp_s), 32'd1);
        check("rst_full",  32'(full_s), 32'd0);
        check("rst_ae",    32'(ae_s), 32'd1);
        check("rst_af",    32'(af_s), 32'd0);
        check("rst_q_std", 32'(q_s), 32'd0);
        check("rst_q_fwft",32'(q_f), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill to full, watching the almost-flag thresholds.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            if (i == 2)  check("fill_ae_at2", 32'(ae_s), 32'd1);
            if (i == 3)  check("fill_ae_at3", 32'(ae_s), 32'd0);
            if (i == 13) check("fill_af_at13", 32'(af_s), 32'd0);
            if (i == 14) check("fill_af_at14", 32'(af_s), 32'd1);
        end
        check("fill_full",  32'(full_s), 32'd1);
        check("fill_count", 32'(cnt_s), 32'd16);

        step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        check("ovf_set",   32'(ovf_s), 32'd1);
        check("ovf_count", 32'(cnt_s), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            check("drain_q", 32'(q_s), 32'(i));
        end
        check("drain_empty", 32'(emp_s), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("udf_set", 32'(udf_s), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf", 32'(ovf_s), 32'd0);
        check("clr_udf", 32'(udf_s), 32'd0);

        // Steady-state streaming at Count=8 across the pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            check("stream_count", 32'(cnt_s), 32'd8);
            check("stream_q", 32'(q_s), (i < 8) ? 32'(8'h20 + i) : 32'(8'h40 + i - 8));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("stream_last", 32'(q_s), 32'h67);

        // Show-ahead: a single word appears on Q the cycle after it is written.
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        check("fwft_q",     32'(q_f), 32'h5A);
        check("fwft_empty", 32'(emp_f), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("fwft_empty_after_rd", 32'(emp_f), 32'd1);

        // Flush wins over a simultaneous write.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        check("flush_count", 32'(cnt_s), 32'd0);
        check("flush_empty", 32'(emp_s), 32'd1);
        check("flush_ae",    32'(ae_s), 32'd1);
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("post_flush_q", 32'(q_s), 32'h33);

        // Asynchronous reset between edges with Count=7 and an error flag set.
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(cnt_s), 32'd7);
        check("pre_rst_udf",   32'(udf_s), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(cnt_s), 32'd0);
        check("arst_empty", 32'(emp_s), 32'd1);
        check("arst_ae",    32'(ae_s), 32'd1);
        check("arst_udf",   32'(udf_s), 32'd0);
        check("arst_q",     32'(q_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        check("post_rst_count", 32'(cnt_s), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("post_rst_q", 32'(q_s), 32'h99);

        // Randomized traffic with varying fill bias; flush only in the last phase.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 700; n++) begin
                logic w, r, f, c;
                int wp, rp;
                wp = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 60 : 50;
                rp = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 60 : 50;
                w = ($urandom_range(0, 99) < wp);
                r = ($urandom_range(0, 99) < rp);
                f = (ph == 3) && ($urandom_range(0, 39) == 0);
                c = !f && ($urandom_range(0, 24) == 0);
                step(w, r, 8'($urandom), f, c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
